cv32e40p_fetch_ctrl: RTL
========================

# cv32e40p_fetch_ctrl

Fetch-redirect controller for the IF stage. It arbitrates PC-redirect requests from the ID stage, the EX stage, the exception/debug logic and the CSR return path. It sequences the boot fetch, fence.i drain and halt, and drives the IF stage's PC select, PC set, fetch halt and IF/ID valid-clear controls. It sits between `cv32e40p_controller` (requesters) and `cv32e40p_if_stage` (consumer).

## Interface
- No parameters.
- `clk` in 1: core clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `redirect_req_i` in 6: level requests, held by the requester until granted.
  - Bit 0 exception/irq/debug, bit 1 branch (EX), bit 2 mret, bit 3 dret, bit 4 jump (ID), bit 5 fence.i.
- `exc_kind_i` in 3: exception vector kind (EXC_PC_*), valid with bit 0.
- `halt_req_i` in 1: level request to stop fetching (debug halt / sleep).
- `fencei_flush_ack_i` in 1: single-cycle pulse; fence.i drain complete.
- `grant_o` out 6: one-hot grant, same bit order as `redirect_req_i`.
- `pc_set_o` out 1: load IF PC from the redirect mux.
- `pc_mux_o` out 4: PC_* source select.
- `exc_pc_mux_o` out 3: EXC_PC_* select.
- `halt_if_o` out 1: freeze IF/ID.
- `clear_instr_valid_o` out 1: kill the IF/ID instruction.
- `fencei_flush_req_o` out 1: request store/fetch drain.
- `redirect_cnt_o` out 32: taken-redirect counter (see Configuration).

## Operation
- FSM states: RESET, BOOT, FETCH, FENCEI_WAIT, HALTED. All outputs are combinational from state and inputs.
- **RESET**
  - `halt_if_o`=1, all other outputs 0.
  - Always goes to BOOT on the next cycle.
- **BOOT**
  - Drives `pc_set_o`=1, `pc_mux_o`=PC_BOOT, `clear_instr_valid_o`=1, `halt_if_o`=1 for exactly one cycle.
  - Then goes to FETCH. Requests are not granted in BOOT.
- **FETCH**
  - Fixed priority: bit0 > bit1 > bit2 > bit3 > bit4 > bit5. The older instruction wins.
  - The winner gets `grant_o` for one cycle, plus `pc_set_o`=1 and `clear_instr_valid_o`=1 in that same cycle.
  - `pc_mux_o` mapping: PC_EXCEPTION for bit 0 (with `exc_pc_mux_o`=`exc_kind_i`), PC_BRANCH for bit 1, PC_MRET for bit 2, PC_DRET for bit 3, PC_JUMP for bit 4.
  - Bit 5 is the exception to this: its grant drives `pc_set_o`=0 and `halt_if_o`=1, and the FSM goes to FENCEI_WAIT.
  - `halt_req_i` with no redirect request: go to HALTED with `halt_if_o`=1.
  - A redirect request pending in the same cycle as `halt_req_i` is granted first, and `halt_req_i` is re-evaluated next cycle.
- **FENCEI_WAIT**
  - `fencei_flush_req_o`=1, `halt_if_o`=1, no grants.
  - On `fencei_flush_ack_i`, in the same cycle: `pc_set_o`=1, `pc_mux_o`=PC_FENCEI, `clear_instr_valid_o`=1, and next state FETCH.
  - Pending requests, including exceptions, wait until FETCH.
- **HALTED**
  - `halt_if_o`=1.
  - A bit 0 request (debug entry) is granted here exactly as in FETCH and the FSM stays HALTED.
  - Leaves for FETCH when `halt_req_i`=0.
- A request withdrawn before grant is legal and is dropped. `grant_o` is never asserted without the matching request bit.
- Reset mid-operation returns to RESET asynchronously. `fencei_flush_req_o` drops immediately.

## Timing
- Redirect latency is 0 cycles: the grant, `pc_set_o` and the mux select appear in the request cycle. The IF PC loads at the next edge.
- fence.i:
  - Grant at cycle N.
  - `fencei_flush_req_o` from N+1.
  - PC_FENCEI set in the ack cycle.
  - Minimum total is 2 cycles.
- After reset release: RESET for 1 cycle, BOOT for 1 cycle, first FETCH cycle is the 3rd.
- At most one grant per cycle. Back-to-back grants are allowed on consecutive FETCH cycles.

## Configuration
- `CV32E40P_FETCH_CTRL_CNT_EN` defined:
  - 32-bit register increments on every `pc_set_o`=1 cycle except BOOT.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by reset.
- Undefined: `redirect_cnt_o` is tied to 0 and no flops are inferred.

## Structure
- `fetch_ctrl_state_e` (RESET, BOOT, FETCH, FENCEI_WAIT, HALTED) goes into `cv32e40p_pkg`.
- Redirect index constants (REDIR_EXC … REDIR_FENCEI) also go into `cv32e40p_pkg`, alongside the existing PC_* / EXC_PC_* constants.
- One sub-module: `cv32e40p_prio_arbiter`, a parameterised fixed-priority one-hot picker (width 6 here).

## Test plan
- Reset release with no requests:
  - Cycle 2 shows `pc_set_o`=1, `pc_mux_o`=PC_BOOT (4'b0000).
  - Cycle 3 shows `halt_if_o`=0.
- In FETCH, `redirect_req_i`=6'b010010 (branch + jump):
  - `grant_o`=6'b000010, `pc_mux_o`=PC_BRANCH (4'b0011).
  - Jump granted next cycle if still held.
- `redirect_req_i`=6'b000001 with `exc_kind_i`=EXC_PC_IRQ (3'b001): `pc_mux_o`=PC_EXCEPTION (4'b0100), `exc_pc_mux_o`=3'b001, `clear_instr_valid_o`=1.
- fence.i request, ack 5 cycles later:
  - `halt_if_o`=1 throughout the wait.
  - Exception raised in the 2nd wait cycle is not granted until the first FETCH cycle after the PC_FENCEI (4'b0001) set.
- `halt_req_i`=1 in FETCH: HALTED. A debug exception is granted in HALTED. `halt_req_i`=0 returns to FETCH.
- With `CV32E40P_FETCH_CTRL_CNT_EN` defined:
  - 3 redirects give `redirect_cnt_o`=3.
  - Async reset asserted mid-FENCEI_WAIT zeros the counter and `fencei_flush_req_o` immediately.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// Shared constants for the fetch-redirect path: PC mux encodings, exception vector kinds,
// redirect request indices and the fetch-controller state type.
package cv32e40p_pkg;

    localparam logic [3:0] PC_BOOT      = 4'b0000;
    localparam logic [3:0] PC_FENCEI    = 4'b0001;
    localparam logic [3:0] PC_JUMP      = 4'b0010;
    localparam logic [3:0] PC_BRANCH    = 4'b0011;
    localparam logic [3:0] PC_EXCEPTION = 4'b0100;
    localparam logic [3:0] PC_MRET      = 4'b0101;
    localparam logic [3:0] PC_URET      = 4'b0110;
    localparam logic [3:0] PC_DRET      = 4'b0111;

    localparam logic [2:0] EXC_PC_EXCEPTION = 3'b000;
    localparam logic [2:0] EXC_PC_IRQ       = 3'b001;
    localparam logic [2:0] EXC_PC_DBD       = 3'b010;
    localparam logic [2:0] EXC_PC_DBE       = 3'b011;

    localparam int REDIR_EXC    = 0;
    localparam int REDIR_BRANCH = 1;
    localparam int REDIR_MRET   = 2;
    localparam int REDIR_DRET   = 3;
    localparam int REDIR_JUMP   = 4;
    localparam int REDIR_FENCEI = 5;
    localparam int REDIR_NUM    = 6;

    typedef enum logic [2:0] {
        RESET,
        BOOT,
        FETCH,
        FENCEI_WAIT,
        HALTED
    } fetch_ctrl_state_e;

    // PC source for a one-hot redirect grant; fence.i has no direct PC and falls through.
    function automatic logic [3:0] redir_pc_mux(input logic [REDIR_NUM-1:0] gnt);
        logic [3:0] sel;
        sel = PC_BOOT;
        if (gnt[REDIR_EXC])         sel = PC_EXCEPTION;
        else if (gnt[REDIR_BRANCH]) sel = PC_BRANCH;
        else if (gnt[REDIR_MRET])   sel = PC_MRET;
        else if (gnt[REDIR_DRET])   sel = PC_DRET;
        else if (gnt[REDIR_JUMP])   sel = PC_JUMP;
        return sel;
    endfunction

endpackage

// File: rtl/cv32e40p_prio_arbiter.sv
// Fixed-priority one-hot picker: the lowest-index asserted request wins.
module cv32e40p_prio_arbiter #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] gnt
);

    // Two's-complement isolates the lowest set bit.
    assign gnt = req & (~req + WIDTH'(1));

endmodule

// File: rtl/cv32e40p_fetch_ctrl.sv
// IF-stage fetch-redirect controller: boot, redirect arbitration, fence.i drain and halt.
// Optional taken-redirect counter enabled by CV32E40P_FETCH_CTRL_CNT_EN.
//
// state       | meaning
// RESET       | just out of reset, IF frozen
// BOOT        | one-cycle load of the boot PC
// FETCH       | normal fetch, redirect requests arbitrated
// FENCEI_WAIT | fence.i drain in progress, IF frozen
// HALTED      | fetch stopped (debug halt / sleep), debug entry still accepted
module cv32e40p_fetch_ctrl
    import cv32e40p_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REDIR_NUM-1:0] redirect_req_i,
    input  logic [2:0]           exc_kind_i,
    input  logic                 halt_req_i,
    input  logic                 fencei_flush_ack_i,
    output logic [REDIR_NUM-1:0] grant_o,
    output logic                 pc_set_o,
    output logic [3:0]           pc_mux_o,
    output logic [2:0]           exc_pc_mux_o,
    output logic                 halt_if_o,
    output logic                 clear_instr_valid_o,
    output logic                 fencei_flush_req_o,
    output logic [31:0]          redirect_cnt_o
);

    fetch_ctrl_state_e state_q, state_d;
    logic [REDIR_NUM-1:0] arb_gnt;

    cv32e40p_prio_arbiter #(.WIDTH(REDIR_NUM)) u_prio_arbiter (
        .req (redirect_req_i),
        .gnt (arb_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RESET;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d             = state_q;
        grant_o             = '0;
        pc_set_o            = 1'b0;
        pc_mux_o            = PC_BOOT;
        exc_pc_mux_o        = EXC_PC_EXCEPTION;
        halt_if_o           = 1'b0;
        clear_instr_valid_o = 1'b0;
        fencei_flush_req_o  = 1'b0;
        case (state_q)
            RESET: begin
                halt_if_o = 1'b1;
                state_d   = BOOT;
            end
            BOOT: begin
                pc_set_o            = 1'b1;
                pc_mux_o            = PC_BOOT;
                clear_instr_valid_o = 1'b1;
                halt_if_o           = 1'b1;
                state_d             = FETCH;
            end
            FETCH: begin
                grant_o = arb_gnt;
                if (arb_gnt[REDIR_FENCEI]) begin
                    // No PC load yet: the new PC comes after the drain completes.
                    clear_instr_valid_o = 1'b1;
                    halt_if_o           = 1'b1;
                    state_d             = FENCEI_WAIT;
                end else if (|arb_gnt) begin
                    pc_set_o            = 1'b1;
                    clear_instr_valid_o = 1'b1;
                    pc_mux_o            = redir_pc_mux(arb_gnt);
                    if (arb_gnt[REDIR_EXC]) exc_pc_mux_o = exc_kind_i;
                end else if (halt_req_i) begin
                    halt_if_o = 1'b1;
                    state_d   = HALTED;
                end
            end
            FENCEI_WAIT: begin
                fencei_flush_req_o = 1'b1;
                halt_if_o          = 1'b1;
                if (fencei_flush_ack_i) begin
                    pc_set_o            = 1'b1;
                    pc_mux_o            = PC_FENCEI;
                    clear_instr_valid_o = 1'b1;
                    state_d             = FETCH;
                end
            end
            HALTED: begin
                halt_if_o = 1'b1;
                if (redirect_req_i[REDIR_EXC]) begin
                    grant_o[REDIR_EXC]  = 1'b1;
                    pc_set_o            = 1'b1;
                    clear_instr_valid_o = 1'b1;
                    pc_mux_o            = PC_EXCEPTION;
                    exc_pc_mux_o        = exc_kind_i;
                end
                if (!halt_req_i) state_d = FETCH;
            end
            default: state_d = RESET;
        endcase
    end

`ifdef CV32E40P_FETCH_CTRL_CNT_EN
    logic [31:0] redirect_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            redirect_cnt_q <= '0;
        else if (pc_set_o && (state_q != BOOT))
            redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end

    assign redirect_cnt_o = redirect_cnt_q;
`else
    assign redirect_cnt_o = '0;
`endif

endmodule
